// File: rtl/uart_tlm_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tlm_sched_if
// Valid/ready word channel from the telemetry scheduler to the UART
// serialiser. Each word is {tag[3:0], payload[DW-1:0]}.
//
// Parameters:
//   DW         payload width; the word is 4+DW bits wide
// Signals:
//   out_data   word being offered (tag in the top nibble)
//   out_valid  out_data holds a word to transfer
//   out_ready  downstream accepts the word this cycle
// Modports:
//   master     scheduler side (drives data/valid, samples ready)
//   slave      serialiser side (samples data/valid, drives ready)
// -----------------------------------------------------------------------------
interface uart_tlm_sched_if #(
   parameter int DW = 12
);

   logic [DW+3:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/uart_tlm_sched.sv
// -----------------------------------------------------------------------------
// uart_tlm_sched
// Telemetry word scheduler for the UART 16-to-8 serialiser path. Each frame
// it snapshots all NCH channel payloads in one cycle, so a frame is always a
// coherent picture of the game state. It then emits a sync word (tag 4'hF)
// followed by one tagged word per channel, then idles for an inter-frame gap.
//
// Optional feature (macro UART_TLM_DELTA_EN):
//   Channels whose snapshot equals the last value actually sent are skipped
//   (one cycle with out_valid low). Every KEEPALIVE frames a full frame is
//   forced so a receiver that lost sync can rebuild its picture. When the
//   macro is undefined every frame carries every channel and KEEPALIVE is
//   only range-checked.
//
// Parameters:
//   NCH           number of channels (1..15); channel i carries tag i
//   DW            payload width per channel
//   GAP_CYC       idle cycles between frames (0..255, 0 behaves as 1)
//   SYNC_PAYLOAD  payload of the sync word
//   KEEPALIVE     frames between forced full frames in delta mode (1..255)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   enable      frames start only while high
//   ch_data     packed channel payloads; channel i at [i*DW +: DW]
//   tx          word channel (master): out_data, out_valid, out_ready
//   frame_done  one-cycle pulse in the first gap cycle after a frame
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tlm_sched #(
   parameter int            NCH          = 5,
   parameter int            DW           = 12,
   parameter int            GAP_CYC      = 8,
   parameter logic [DW-1:0] SYNC_PAYLOAD = 12'hA5A,
   parameter int            KEEPALIVE    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [NCH*DW-1:0]     ch_data,
   uart_tlm_sched_if.master      tx,
   output logic                  frame_done,
   output logic                  busy
);

   // Out-of-range parameters would silently corrupt the tag space or the
   // counters, so refuse to elaborate instead.
   if (NCH < 1 || NCH > 15 || DW < 1 || GAP_CYC < 0 || GAP_CYC > 255 ||
       KEEPALIVE < 1 || KEEPALIVE > 255) begin : g_param_check
      $error("uart_tlm_sched: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      SYNC,
      CHAN,
      GAP
   } state_t;

   localparam logic [3:0] SYNC_TAG = 4'hF;
   localparam logic [3:0] IDX_LAST = 4'(NCH - 1);

   // The gap counter counts down to zero inclusive, so it is loaded with one
   // less than the wanted number of gap cycles; a zero gap still costs the
   // single cycle needed to pass through GAP.
   localparam logic [7:0] GAP_LOAD = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

   state_t              state;
   state_t              state_nx;
   logic [3:0]          idx;
   logic [3:0]          idx_nx;
   logic [7:0]          gap_cnt;
   logic [7:0]          gap_nx;
   logic [NCH*DW-1:0]   snap;
   logic [DW+3:0]       data_nx;
   logic                valid_nx;
   logic                xfer;
   logic                skip_nx;
   logic [DW-1:0]       snap_sel;

   assign xfer = tx.out_valid & tx.out_ready;

   // Payload of the channel that will be presented next cycle. Only the
   // snapshot is ever read, never the live ch_data, which keeps a frame
   // coherent even if the game state changes while it is being sent.
   always_comb begin
      snap_sel = snap[int'(idx_nx)*DW +: DW];
   end

   // Next-state logic. In CHAN a cycle with out_valid low is a skipped
   // channel (delta mode only) and advances exactly like a transfer does.
   // A stalled word keeps state and idx unchanged, so the registered
   // outputs recompute to the same values and stay stable.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      gap_nx   = gap_cnt;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nx = SNAP;
            end
         end
         SNAP: begin
            state_nx = SYNC;
            idx_nx   = 4'd0;
         end
         SYNC: begin
            if (xfer) begin
               state_nx = CHAN;
            end
         end
         CHAN: begin
            if (xfer || !tx.out_valid) begin
               if (idx == IDX_LAST) begin
                  state_nx = GAP;
                  gap_nx   = GAP_LOAD;
               end else begin
                  idx_nx = idx + 4'd1;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'd0) begin
               state_nx = enable ? SNAP : IDLE;
            end else begin
               gap_nx = gap_cnt - 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Output words are computed from where the FSM is going so that every
   // output can be a plain register. Outside SYNC/CHAN the data bus simply
   // holds its last value with out_valid low.
   always_comb begin
      data_nx  = tx.out_data;
      valid_nx = 1'b0;
      unique case (state_nx)
         SYNC: begin
            data_nx  = {SYNC_TAG, SYNC_PAYLOAD};
            valid_nx = 1'b1;
         end
         CHAN: begin
            data_nx  = {idx_nx, snap_sel};
            valid_nx = !skip_nx;
         end
         default: begin
            valid_nx = 1'b0;
         end
      endcase
   end

`ifdef UART_TLM_DELTA_EN
   localparam logic [7:0] KA_LAST = 8'(KEEPALIVE - 1);

   logic [NCH*DW-1:0] last_sent;
   logic [7:0]        frame_cnt;
   logic [DW-1:0]     last_sel;

   // Frame 0 of every keep-alive period is sent in full; otherwise a
   // channel is skipped when its snapshot matches what the receiver has.
   always_comb begin
      last_sel = last_sent[int'(idx_nx)*DW +: DW];
      skip_nx  = (frame_cnt != 8'd0) && (snap_sel == last_sel);
   end

   // last_sent only changes on a real transfer of that channel, so a word
   // lost to reset is resent next time. The frame counter steps on the same
   // edge that raises frame_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_sent <= '0;
         frame_cnt <= 8'd0;
      end else begin
         if (state == CHAN && xfer) begin
            last_sent[int'(idx)*DW +: DW] <= snap[int'(idx)*DW +: DW];
         end
         if (state == CHAN && state_nx == GAP) begin
            frame_cnt <= (frame_cnt == KA_LAST) ? 8'd0 : frame_cnt + 8'd1;
         end
      end
   end
`else
   assign skip_nx = 1'b0;
`endif

   // State, snapshot and all outputs. Reset clears the outputs immediately,
   // so a word pending at reset is dropped rather than left on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= 4'd0;
         gap_cnt      <= 8'd0;
         snap         <= '0;
         tx.out_data  <= '0;
         tx.out_valid <= 1'b0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         idx          <= idx_nx;
         gap_cnt      <= gap_nx;
         if (state == SNAP) begin
            snap <= ch_data;
         end
         tx.out_data  <= data_nx;
         tx.out_valid <= valid_nx;
         frame_done   <= (state == CHAN) && (state_nx == GAP);
         busy         <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tlm_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tlm_sched
// Directed bench for uart_tlm_sched with NCH=4, DW=12, GAP_CYC=2,
// KEEPALIVE=3. Inputs change and outputs are sampled on the falling edge.
// The delta-mode scenario is compiled only with UART_TLM_DELTA_EN.
// -----------------------------------------------------------------------------
module tb_uart_tlm_sched;

   localparam int NCH = 4;
   localparam int DW  = 12;

   logic              clk;
   logic              rst;
   logic              enable;
   logic [NCH*DW-1:0] ch_data;
   logic              frame_done;
   logic              busy;

   int nChecks;
   int nFails;

   localparam logic [NCH*DW-1:0] BASE_DATA = {12'h444, 12'h333, 12'h222, 12'h111};

   uart_tlm_sched_if #(.DW(DW)) bus ();

   uart_tlm_sched #(
      .NCH          (NCH),
      .DW           (DW),
      .GAP_CYC      (2),
      .SYNC_PAYLOAD (12'hA5A),
      .KEEPALIVE    (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .ch_data    (ch_data),
      .tx         (bus),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Puts the DUT in IDLE with enable and out_ready low; returns on a
   // falling edge with reset released.
   task automatic applyStimulus_reset();
      rst           = 1'b1;
      enable        = 1'b0;
      bus.out_ready = 1'b0;
      ch_data       = BASE_DATA;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      enable        = 1'b1;
      bus.out_ready = 1'b1;
      ch_data       = BASE_DATA;
      repeat (3) @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid);
      end
      nChecks++;
      if (bus.out_data !== 16'h0000) begin
         nFails++;
         $display("[TB] FAIL reset_data: got %h want 0000", bus.out_data);
      end
      nChecks++;
      if ({busy, frame_done} !== 2'b00) begin
         nFails++;
         $display("[TB] FAIL reset_busy_fd: got %b want 00", {busy, frame_done});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      logic [15:0] expWords [5];
      expWords = '{16'hFA5A, 16'h0111, 16'h1222, 16'h2333, 16'h3444};
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      @(negedge clk);
      nChecks++;
      if ({busy, bus.out_valid} !== 2'b10) begin
         nFails++;
         $display("[TB] FAIL snap_cycle: busy/valid got %b want 10", {busy, bus.out_valid});
      end
      for (int w = 0; w < 5; w++) begin
         @(negedge clk);
         nChecks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== expWords[w]) begin
            nFails++;
            $display("[TB] FAIL basic_word%0d: got v=%b %h want v=1 %h",
                     w, bus.out_valid, bus.out_data, expWords[w]);
         end
      end
      @(negedge clk);
      nChecks++;
      if ({frame_done, bus.out_valid, busy} !== 3'b101) begin
         nFails++;
         $display("[TB] FAIL basic_frame_done: fd/valid/busy got %b want 101",
                  {frame_done, bus.out_valid, busy});
      end
      @(negedge clk);
      nChecks++;
      if ({frame_done, bus.out_valid} !== 2'b00) begin
         nFails++;
         $display("[TB] FAIL basic_gap2: fd/valid got %b want 00", {frame_done, bus.out_valid});
      end
      repeat (2) @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFA5A) begin
         nFails++;
         $display("[TB] FAIL basic_next_sync: got v=%b %h want v=1 fa5a",
                  bus.out_valid, bus.out_data);
      end
      enable = 1'b0;
   endtask

   task automatic test_stall();
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      repeat (4) @(negedge clk);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         nChecks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1222) begin
            nFails++;
            $display("[TB] FAIL stall_hold%0d: got v=%b %h want v=1 1222",
                     c, bus.out_valid, bus.out_data);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h2333) begin
         nFails++;
         $display("[TB] FAIL stall_resume: got v=%b %h want v=1 2333",
                  bus.out_valid, bus.out_data);
      end
      @(negedge clk);
      nChecks++;
      if (bus.out_data !== 16'h3444) begin
         nFails++;
         $display("[TB] FAIL stall_last: got %h want 3444", bus.out_data);
      end
      @(negedge clk);
      nChecks++;
      if (frame_done !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL stall_frame_done: got %b want 1", frame_done);
      end
      enable = 1'b0;
   endtask

   task automatic test_snap_coherence();
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      repeat (2) @(negedge clk);
      ch_data[11:0] = 12'hABC;
      @(negedge clk);
      nChecks++;
      if (bus.out_data !== 16'h0111) begin
         nFails++;
         $display("[TB] FAIL coherent_frame: got %h want 0111", bus.out_data);
      end
      repeat (7) @(negedge clk);
      nChecks++;
      if (bus.out_data !== 16'hFA5A) begin
         nFails++;
         $display("[TB] FAIL coherent_sync2: got %h want fa5a", bus.out_data);
      end
      @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0ABC) begin
         nFails++;
         $display("[TB] FAIL coherent_next: got v=%b %h want v=1 0abc",
                  bus.out_valid, bus.out_data);
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      nChecks++;
      if (bus.out_data !== 16'h3444) begin
         nFails++;
         $display("[TB] FAIL drop_finish: got %h want 3444", bus.out_data);
      end
      repeat (2) @(negedge clk);
      nChecks++;
      if (busy !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL drop_gap_busy: got %b want 1", busy);
      end
      @(negedge clk);
      nChecks++;
      if ({busy, bus.out_valid} !== 2'b00) begin
         nFails++;
         $display("[TB] FAIL drop_idle: busy/valid got %b want 00", {busy, bus.out_valid});
      end
      repeat (3) @(negedge clk);
      nChecks++;
      if ({busy, bus.out_valid} !== 2'b00) begin
         nFails++;
         $display("[TB] FAIL drop_stays_idle: busy/valid got %b want 00", {busy, bus.out_valid});
      end
   endtask

   task automatic test_reset_mid_frame();
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      repeat (5) @(negedge clk);
      bus.out_ready = 1'b0;
      @(negedge clk);
      nChecks++;
      if (bus.out_data !== 16'h2333) begin
         nFails++;
         $display("[TB] FAIL rstmid_pending: got %h want 2333", bus.out_data);
      end
      #2 rst = 1'b1;
      #1;
      nChecks++;
      if ({bus.out_valid, busy} !== 2'b00 || bus.out_data !== 16'h0000) begin
         nFails++;
         $display("[TB] FAIL rstmid_async: valid/busy %b data %h want 00 0000",
                  {bus.out_valid, busy}, bus.out_data);
      end
      @(negedge clk);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      nChecks++;
      if ({busy, bus.out_valid} !== 2'b10) begin
         nFails++;
         $display("[TB] FAIL rstmid_snap: busy/valid got %b want 10", {busy, bus.out_valid});
      end
      @(negedge clk);
      nChecks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFA5A) begin
         nFails++;
         $display("[TB] FAIL rstmid_restart: got v=%b %h want v=1 fa5a",
                  bus.out_valid, bus.out_data);
      end
      enable = 1'b0;
   endtask

   // Steady streaming: sync-to-sync period must be 1+1+NCH+2 = 8 cycles
   // with exactly NCH+1 valid cycles in between.
   task automatic test_back_to_back();
      int cyc;
      int nValid;
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(bus.out_valid === 1'b1 && bus.out_data === 16'hFA5A) && cyc < 10);
      nChecks++;
      if (cyc >= 10) begin
         nFails++;
         $display("[TB] FAIL b2b_first_sync: no sync within %0d cycles", cyc);
      end
      cyc    = 0;
      nValid = 0;
      do begin
         if (bus.out_valid === 1'b1) nValid++;
         @(negedge clk);
         cyc++;
      end while (!(bus.out_valid === 1'b1 && bus.out_data === 16'hFA5A) && cyc < 20);
      nChecks++;
      if (cyc !== 8) begin
         nFails++;
         $display("[TB] FAIL b2b_period: got %0d cycles want 8", cyc);
      end
      nChecks++;
      if (nValid !== 5) begin
         nFails++;
         $display("[TB] FAIL b2b_words: got %0d valid cycles want 5", nValid);
      end
      enable = 1'b0;
   endtask

`ifdef UART_TLM_DELTA_EN
   // Frame 0 full (channel 2 changes after its snapshot), frame 1 sends
   // sync plus the changed channel, frame 2 sync only, frame 3 full again.
   task automatic test_delta();
      logic [15:0] words [8];
      int          nWords [4];
      logic [15:0] lastWord [4];
      logic [15:0] frame1Ch;
      int          cyc;
      frame1Ch = 16'h0000;
      applyStimulus_reset();
      bus.out_ready = 1'b1;
      enable        = 1'b1;
      for (int f = 0; f < 4; f++) begin
         nWords[f]   = 0;
         lastWord[f] = 16'h0000;
         cyc         = 0;
         do begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
               if (nWords[f] < 8) words[nWords[f]] = bus.out_data;
               lastWord[f] = bus.out_data;
               nWords[f]++;
               if (f == 0 && nWords[f] == 1) ch_data[35:24] = 12'h777;
               if (f == 1 && nWords[f] == 2) frame1Ch = bus.out_data;
            end
         end while (frame_done !== 1'b1 && cyc < 40);
         nChecks++;
         if (cyc >= 40) begin
            nFails++;
            $display("[TB] FAIL delta_timeout: frame %0d never completed", f);
         end
      end
      nChecks++;
      if (nWords[0] !== 5 || lastWord[0] !== 16'h3444) begin
         nFails++;
         $display("[TB] FAIL delta_frame0: got %0d words last %h want 5 3444", nWords[0], lastWord[0]);
      end
      nChecks++;
      if (nWords[1] !== 2 || frame1Ch !== 16'h2777) begin
         nFails++;
         $display("[TB] FAIL delta_frame1: got %0d words ch %h want 2 2777", nWords[1], frame1Ch);
      end
      nChecks++;
      if (nWords[2] !== 1 || lastWord[2] !== 16'hFA5A) begin
         nFails++;
         $display("[TB] FAIL delta_frame2: got %0d words last %h want 1 fa5a", nWords[2], lastWord[2]);
      end
      nChecks++;
      if (nWords[3] !== 5 || words[3] !== 16'h2777) begin
         nFails++;
         $display("[TB] FAIL delta_frame3: got %0d words ch2 %h want 5 2777", nWords[3], words[3]);
      end
      enable = 1'b0;
   endtask
`endif

   initial begin
      nChecks       = 0;
      nFails        = 0;
      rst           = 1'b1;
      enable        = 1'b0;
      bus.out_ready = 1'b0;
      ch_data       = BASE_DATA;
      test_reset();
      test_basic_frame();
      test_stall();
      test_snap_coherence();
      test_enable_drop();
      test_reset_mid_frame();
      test_back_to_back();
`ifdef UART_TLM_DELTA_EN
      test_delta();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
